// File: rtl/status_cond_unit_pkg.sv
// Shared definitions for the status/condition logic.
// Flag bit positions within the 4-bit {N,Z,C,V} status word and the ARM
// condition-field encodings. Decode and the ALU import these as well.
package status_cond_unit_pkg;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/status_cond_unit_cond_eval.sv
// Combinational ARM condition evaluator, shared with the branch unit.
// Ports:
//   cond  in  4  condition field
//   nzcv  in  4  flags {N,Z,C,V}
//   pass  out 1  condition satisfied; the reserved encoding never passes
module cond_eval
  import status_cond_unit_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// Architectural NZCV status register with condition evaluation for decode,
// a one-deep saved-status slot for exceptions and a saturating count of
// committed flag writes.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   exe_valid     EXE holds a valid instruction
//   exe_s         EXE instruction updates flags
//   alu_status    {N,Z,C,V} produced by the ALU this cycle
//   flush         kills the EXE instruction's flag write
//   id_cond       condition field of the decode instruction
//   exc_enter     exception entry pulse (saves status)
//   exc_return    exception return pulse (restores status)
//   status_q      committed NZCV
//   c_in          committed carry to the ALU (never bypassed)
//   cond_pass     decode condition satisfied
//   saved_q       saved NZCV slot
//   saved_valid   saved slot is live
//   upd_cnt       committed flag writes, saturating
module status_cond_unit
  import status_cond_unit_pkg::*;
#(
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exe_valid,
  input  logic             exe_s,
  input  logic [3:0]       alu_status,
  input  logic             flush,
  input  logic [3:0]       id_cond,
  input  logic             exc_enter,
  input  logic             exc_return,
  output logic [3:0]       status_q,
  output logic             c_in,
  output logic             cond_pass,
  output logic [3:0]       saved_q,
  output logic             saved_valid,
  output logic [CNT_W-1:0] upd_cnt
);

  logic       we;
  logic       restore;
  logic [3:0] eff;

  assign we = exe_valid & exe_s & ~flush;
  // Entry takes priority over return; a return with an empty slot is ignored.
  assign restore = exc_return & saved_valid & ~exc_enter;

  assign eff  = (BYPASS && we) ? alu_status : status_q;
  assign c_in = status_q[FLAG_C];

  cond_eval u_cond_eval (
    .cond (id_cond),
    .nzcv (eff),
    .pass (cond_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q    <= '0;
      saved_q     <= '0;
      saved_valid <= 1'b0;
      upd_cnt     <= '0;
    end else begin
      if (exc_enter) begin
        saved_q     <= status_q;
        saved_valid <= 1'b1;
      end else if (restore) begin
        saved_valid <= 1'b0;
      end

      // A restore overrides and drops any same-cycle flag write.
      if (restore) begin
        status_q <= saved_q;
      end else if (we) begin
        status_q <= alu_status;
        if (upd_cnt != '1) begin
          upd_cnt <= upd_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Holds the architectural NZCV status register fed by the execute-stage ALU's 4-bit status output {N,Z,C,V}.
- Supplies the committed carry back to the ALU as its carry input.
- Evaluates the 4-bit ARM condition field of the instruction in decode, with same-cycle bypass of the flags being produced in execute.
- Provides a one-deep saved-status (SPSR-like) slot for exception entry/return, plus a saturating flag-update counter for debug.

Parameters:
- BYPASS, 1, 1 = condition check sees flags written by the EXE instruction in the same cycle; 0 = committed flags only.
- CNT_W, 16, width of the flag-update counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- exe_valid  in  1  EXE stage holds a valid instruction.
- exe_s  in  1  S bit of the EXE instruction; the instruction updates flags.
- alu_status  in  4  {N,Z,C,V} from the ALU, same cycle.
- flush  in  1  kills the EXE instruction; blocks its flag write.
- id_cond  in  4  condition field of the decode-stage instruction.
- exc_enter  in  1  exception entry pulse.
- exc_return  in  1  exception return pulse.
- status_q  out  4  committed NZCV.
- c_in  out  1  equals status_q[1]; drives the ALU carry input.
- cond_pass  out  1  decode instruction condition satisfied (combinational).
- saved_q  out  4  saved NZCV slot.
- saved_valid  out  1  saved slot holds live data.
- upd_cnt  out  CNT_W  number of committed flag writes, saturating.

Behaviour:
- Reset (async, rst_n=0): status_q=4'b0000, saved_q=4'b0000, saved_valid=0, upd_cnt=0. cond_pass follows the reset flags; AL passes, EQ fails.
- Commit condition: we = exe_valid & exe_s & ~flush. On a clk edge with we=1, status_q <= alu_status and upd_cnt increments. At all-ones the counter holds.
- Flag-write latency: flags are visible on status_q one cycle after the EXE cycle.
- c_in is always the committed carry, never bypassed: the EXE instruction reads the flags that existed before itself.
- Effective flags: eff = (BYPASS & we) ? alu_status : status_q.
- cond_pass decode from eff {N,Z,C,V}:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 reserved, returns 0.
- Exception entry (exc_enter=1): saved_q <= status_q (the pre-edge value), saved_valid <= 1. A same-cycle we still commits alu_status to status_q.
- Exception return (exc_return=1, saved_valid=1): status_q <= saved_q, saved_valid <= 0. A same-cycle we is dropped and upd_cnt does not increment.
- exc_return with saved_valid=0: ignored; we proceeds normally.
- exc_enter and exc_return in the same cycle: exc_enter wins and exc_return is ignored.
- A second exc_enter while saved_valid=1 overwrites the slot (one-deep, no nesting).
- flush has no effect on the saved slot or on exception pulses.
- Reset asserted mid-operation clears all state immediately, independent of clk.

Decomposition:
- Shared package: flag bit indices (N=3, Z=2, C=1, V=0) and the 16 condition-code constants, also used by decode and the ALU.
- Natural sub-module: cond_eval, a purely combinational mapping of (cond[3:0], nzcv[3:0]) to pass. It is reused by the branch unit.

Test Plan:
- Reset and pass check: assert rst_n=0, release, id_cond=1110 -> status_q=0, upd_cnt=0, cond_pass=1; with id_cond=0000 -> cond_pass=0.
- Commit and bypass: exe_valid=1, exe_s=1, alu_status=0100, id_cond=0000 -> cond_pass=1 in the same cycle; next cycle status_q=0100, upd_cnt=1. Repeat with BYPASS=0 -> cond_pass=0 in the same cycle, then 1 after the edge.
- Flush and S=0: alu_status=1000 with flush=1 or exe_s=0 -> status_q unchanged, upd_cnt unchanged; c_in unchanged.
- Exception round-trip: status_q=0010, pulse exc_enter together with we and alu_status=1001 -> saved_q=0010, status_q=1001. Later pulse exc_return together with we and alu_status=0100 -> status_q=0010, saved_valid=0, upd_cnt not incremented.
- Signed conditions: sweep all 16 nzcv values x 16 conds against a reference model. Spot checks: nzcv=1001 -> GE=1, GT=1, LT=0; nzcv=1000 -> LT=1, LE=1; cond 1111 -> 0 always.
- Counter saturation: CNT_W=4, 20 commits -> upd_cnt=15 and holds. Async rst_n pulse mid-stream -> all outputs zero before the next edge.
